rand_sram_bist_ctrl: RTL

Sequencer for the 8-bit LFSR random generator and the demo SRAM.
- Fills every SRAM address with the generator's pseudo-random stream.
- Reloads the same seed, reads every address back and compares each word against the regenerated stream.
- Reports pass/fail, the error count and the first failing address.
- Sits between the top-level button/switch logic and the SRAM port. It is the sole driver of the generator's LOAD_SEED/GET_NEXT inputs.

---
 rtl/rand_sram_bist_ctrl_pkg.sv | 18 +
 rtl/rand_sram_bist_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rand_sram_bist_ctrl_pkg.sv
// Shared state encoding and default widths for the random SRAM BIST sequencer.
package rand_sram_bist_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADW = 3'd1,
    S_WRITE = 3'd2,
    S_LOADR = 3'd3,
    S_RD    = 3'd4,
    S_CMP   = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int SEED_W     = 8;

endpackage

// File: rtl/rand_sram_bist_ctrl.sv
// Fills the SRAM from the LFSR stream, replays the seed and verifies every word.
// Strobes and address are registered so they are asserted during the state they belong to.
module rand_sram_bist_ctrl
  import rand_sram_bist_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [SEED_W-1:0] SEED,
  output logic              RG_LOAD_SEED,
  output logic              RG_GET_NEXT,
  output logic [SEED_W-1:0] RG_SEED,
  input  logic [DATA_W-1:0] RG_VAL,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE,
  output logic              SRAM_RE,
  output logic [DATA_W-1:0] SRAM_WDATA,
  input  logic [DATA_W-1:0] SRAM_RDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [ADDR_W:0]   ERR_COUNT,
  output logic [ADDR_W-1:0] FIRST_ERR_ADDR
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [SEED_W-1:0]   seed_q;
  logic                first_seen;
  logic                mismatch;
  logic [ADDR_W:0]     err_next;

  assign SRAM_ADDR  = addr;
  assign RG_SEED    = seed_q;
  assign SRAM_WDATA = RG_VAL;
  assign mismatch   = (SRAM_RDATA != RG_VAL);
  assign err_next   = ERR_COUNT + {{ADDR_W{1'b0}}, mismatch};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= S_IDLE;
      addr           <= '0;
      seed_q         <= '0;
      first_seen     <= 1'b0;
      RG_LOAD_SEED   <= 1'b0;
      RG_GET_NEXT    <= 1'b0;
      SRAM_WE        <= 1'b0;
      SRAM_RE        <= 1'b0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      PASS           <= 1'b0;
      ERR_COUNT      <= '0;
      FIRST_ERR_ADDR <= '0;
    end else begin
      RG_LOAD_SEED <= 1'b0;
      RG_GET_NEXT  <= 1'b0;
      SRAM_WE      <= 1'b0;
      SRAM_RE      <= 1'b0;
      DONE         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            seed_q         <= SEED;
            ERR_COUNT      <= '0;
            FIRST_ERR_ADDR <= '0;
            PASS           <= 1'b0;
            first_seen     <= 1'b0;
            addr           <= '0;
            BUSY           <= 1'b1;
            RG_LOAD_SEED   <= 1'b1;
            state          <= S_LOADW;
          end
        end
        S_LOADW: begin
          addr        <= '0;
          SRAM_WE     <= 1'b1;
          RG_GET_NEXT <= 1'b1;
          state       <= S_WRITE;
        end
        S_WRITE: begin
          addr <= addr + 1'b1;
          if (addr == ADDR_LAST) begin
            RG_LOAD_SEED <= 1'b1;
            state        <= S_LOADR;
          end else begin
            SRAM_WE     <= 1'b1;
            RG_GET_NEXT <= 1'b1;
          end
        end
        S_LOADR: begin
          SRAM_RE <= 1'b1;
          state   <= S_RD;
        end
        S_RD: begin
          // Read data and the regenerated word both become valid in CMP.
          RG_GET_NEXT <= 1'b1;
          state       <= S_CMP;
        end
        S_CMP: begin
          ERR_COUNT <= err_next;
          if (mismatch && !first_seen) begin
            FIRST_ERR_ADDR <= addr;
            first_seen     <= 1'b1;
          end
          addr <= addr + 1'b1;
          if (addr == ADDR_LAST) begin
            // PASS uses the final count so it is valid alongside DONE.
            DONE  <= 1'b1;
            PASS  <= (err_next == '0);
            state <= S_FIN;
          end else begin
            SRAM_RE <= 1'b1;
            state   <= S_RD;
          end
        end
        S_FIN: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
